iter_alu: RTL and testbench

- Parametrised, registered successor to the combinational EX-stage ALU.
- Adds signed and unsigned compare, XOR/NOR, and shifts.
- Adds an iterative multiply/divide unit that owns the architectural HI/LO registers.
- Uses a valid/ready/done handshake so the pipeline controller can stall on long operations and flush them on exceptions.

---
 rtl/iter_alu.sv | 196 +++++++++++++++++++
 tb/tb_iter_alu.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - registered EX-stage ALU with iterative multiply/divide and HI/LO
module iter_alu #(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             W_clk,
  input  logic             W_rst_n,
  input  logic             W_valid,
  input  logic [3:0]       W_op_sel,
  input  logic [WIDTH-1:0] W_a,
  input  logic [WIDTH-1:0] W_b,
  input  logic             W_flush,
  output logic             R_ready,
  output logic             R_done,
  output logic [WIDTH-1:0] R_res,
  output logic [WIDTH-1:0] R_hi,
  output logic [WIDTH-1:0] R_lo
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_cnt;

  // Working registers shared by MUL (product high/low, multiplicand)
  // and DIV (partial remainder, shifting quotient, divisor).
  logic [WIDTH-1:0] r_hi_w;
  logic [WIDTH-1:0] r_lo_w;
  logic [WIDTH-1:0] r_opnd;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_accept;
  logic             w_op_md;
  logic             w_op_mul;
  logic             w_op_signed;
  logic             w_start_md;
  logic             w_last;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [SW-1:0]    w_shamt;
  logic [WIDTH-1:0] w_alu_res;

  logic             w_mode_mul;
  logic [WIDTH-1:0] w_in_hi;
  logic [WIDTH-1:0] w_in_lo;
  logic [WIDTH-1:0] w_in_op;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_fin_hi;
  logic [WIDTH-1:0]   w_fin_lo;

  assign w_accept    = W_valid && R_ready && !W_flush;
  assign w_op_md     = (W_op_sel >= 4'd11) && (W_op_sel <= 4'd14);
  assign w_op_mul    = (W_op_sel == 4'd11) || (W_op_sel == 4'd12);
  assign w_op_signed = (W_op_sel == 4'd11) || (W_op_sel == 4'd13);
  assign w_start_md  = w_accept && w_op_md && MULDIV_EN;
  assign w_last      = (r_state != S_IDLE) && (r_cnt == CW'(1));
  assign w_shamt     = W_a[SW-1:0];

  assign w_sign_a = w_op_signed && W_a[WIDTH-1];
  assign w_sign_b = w_op_signed && W_b[WIDTH-1];
  assign w_mag_a  = w_sign_a ? -W_a : W_a;
  assign w_mag_b  = w_sign_b ? -W_b : W_b;

  // Single-cycle ALU result; mul/div and reserved opcodes yield zero here
  always_comb begin
    w_alu_res = '0;
    case (W_op_sel)
      4'd0:    w_alu_res = W_a + W_b;
      4'd1:    w_alu_res = W_a - W_b;
      4'd2:    w_alu_res = W_a & W_b;
      4'd3:    w_alu_res = W_a | W_b;
      4'd4:    w_alu_res[0] = $signed(W_a) < $signed(W_b);
      4'd5:    w_alu_res = W_a ^ W_b;
      4'd6:    w_alu_res = ~(W_a | W_b);
      4'd7:    w_alu_res[0] = W_a < W_b;
      4'd8:    w_alu_res = W_b << w_shamt;
      4'd9:    w_alu_res = W_b >> w_shamt;
      4'd10:   w_alu_res = $signed(W_b) >>> w_shamt;
      default: w_alu_res = '0;
    endcase
  end

  // One mul/div step; the accept edge runs the first step straight from the
  // operand magnitudes so the last step lands WIDTH-1 edges later
  always_comb begin
    w_mode_mul = w_start_md ? w_op_mul : (r_state == S_MUL);
    w_in_hi    = w_start_md ? '0 : r_hi_w;
    w_in_lo    = w_start_md ? w_mag_a : r_lo_w;
    w_in_op    = w_start_md ? w_mag_b : r_opnd;
    w_sum      = {1'b0, w_in_hi} + (w_in_lo[0] ? {1'b0, w_in_op} : '0);
    w_shift    = {w_in_hi, w_in_lo[WIDTH-1]};
    w_diff     = w_shift - {1'b0, w_in_op};
    if (w_mode_mul) begin
      w_step_hi = w_sum[WIDTH:1];
      w_step_lo = {w_sum[0], w_in_lo[WIDTH-1:1]};
    end else begin
      w_step_hi = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_step_lo = {w_in_lo[WIDTH-2:0], ~w_diff[WIDTH]};
    end
  end

  // Sign correction of the finished magnitude result
  always_comb begin
    w_prod     = {w_step_hi, w_step_lo};
    w_prod_fix = r_neg_q ? -w_prod : w_prod;
    if (r_state == S_MUL) begin
      w_fin_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_fin_lo = w_prod_fix[WIDTH-1:0];
    end else begin
      w_fin_hi = r_neg_r ? -w_step_hi : w_step_hi;
      w_fin_lo = r_neg_q ? -w_step_lo : w_step_lo;
    end
  end

  // FSM state register
  always_ff @(posedge W_clk or negedge W_rst_n) begin
    if (!W_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // FSM next state: flush always wins, busy states leave on the last step
  always_comb begin
    w_next_state = r_state;
    if (W_flush) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:        if (w_start_md) w_next_state = w_op_mul ? S_MUL : S_DIV;
        S_MUL, S_DIV:  if (r_cnt == CW'(1)) w_next_state = S_IDLE;
        default:       w_next_state = S_IDLE;
      endcase
    end
  end

  // FSM output: ready only when no mul/div is in flight
  always_comb begin
    R_ready = (r_state == S_IDLE);
  end

  // Datapath: result, HI/LO, done pulse, counter and working registers
  always_ff @(posedge W_clk or negedge W_rst_n) begin
    if (!W_rst_n) begin
      R_res   <= '0;
      R_hi    <= '0;
      R_lo    <= '0;
      R_done  <= 1'b0;
      r_cnt   <= '0;
      r_hi_w  <= '0;
      r_lo_w  <= '0;
      r_opnd  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      R_done <= 1'b0;
      if (W_flush) begin
        r_cnt <= '0;
      end else if (w_start_md) begin
        r_hi_w  <= w_step_hi;
        r_lo_w  <= w_step_lo;
        r_opnd  <= w_in_op;
        r_neg_q <= w_sign_a ^ w_sign_b;
        r_neg_r <= w_sign_a;
        r_cnt   <= CW'(WIDTH - 1);
      end else if (w_accept) begin
        R_res  <= w_alu_res;
        R_done <= 1'b1;
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt - CW'(1);
        if (w_last) begin
          R_hi   <= w_fin_hi;
          R_lo   <= w_fin_lo;
          R_res  <= w_fin_lo;
          R_done <= 1'b1;
        end else begin
          r_hi_w <= w_step_hi;
          r_lo_w <= w_step_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// tb/tb_iter_alu.sv - directed self-checking bench for iter_alu (WIDTH 32 and 8)
module tb_iter_alu;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        ready;
  logic        done;
  logic [31:0] res;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        valid8;
  logic [3:0]  op8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        flush8;
  logic        ready8;
  logic        done8;
  logic [7:0]  res8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  int errors = 0;
  int checks = 0;

  iter_alu #(.WIDTH(32), .MULDIV_EN(1'b1)) u_dut32 (
    .W_clk(clk), .W_rst_n(rst_n), .W_valid(valid), .W_op_sel(op),
    .W_a(a), .W_b(b), .W_flush(flush),
    .R_ready(ready), .R_done(done), .R_res(res), .R_hi(hi), .R_lo(lo)
  );

  iter_alu #(.WIDTH(8), .MULDIV_EN(1'b1)) u_dut8 (
    .W_clk(clk), .W_rst_n(rst_n), .W_valid(valid8), .W_op_sel(op8),
    .W_a(a8), .W_b(b8), .W_flush(flush8),
    .R_ready(ready8), .R_done(done8), .R_res(res8), .R_hi(hi8), .R_lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue1(input logic [3:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b);
    @(negedge clk);
    valid = 1'b1; op = t_op; a = t_a; b = t_b;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic run_md32(input logic [3:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                          output int lat, output int low);
    @(negedge clk);
    valid = 1'b1; op = t_op; a = t_a; b = t_b;
    @(posedge clk);
    lat = 0;
    low = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      valid = 1'b0;
      if (!ready) low++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b1)  begin errors++; $display("FAIL reset_ready got %b expected 1", ready); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (res !== 32'd0)   begin errors++; $display("FAIL reset_res got %h expected 0", res); end
    checks++; if (hi !== 32'd0)    begin errors++; $display("FAIL reset_hi got %h expected 0", hi); end
    checks++; if (lo !== 32'd0)    begin errors++; $display("FAIL reset_lo got %h expected 0", lo); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    valid = 1'b1; op = 4'd0; a = 32'hFFFF_FFFF; b = 32'd1;
    @(posedge clk); @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_add_done got %b expected 1", done); end
    checks++; if (res !== 32'd0) begin errors++; $display("FAIL b2b_add_res got %h expected 0", res); end
    op = 4'd4;
    @(posedge clk); @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_slt_done got %b expected 1", done); end
    checks++; if (res !== 32'd1) begin errors++; $display("FAIL b2b_slt_res got %h expected 1", res); end
    op = 4'd7;
    @(posedge clk); @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_sltu_done got %b expected 1", done); end
    checks++; if (res !== 32'd0) begin errors++; $display("FAIL b2b_sltu_res got %h expected 0", res); end
    valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_idle_done got %b expected 0", done); end
  endtask

  task automatic test_logic_shift;
    issue1(4'd10, 32'd4, 32'h8000_0000);
    checks++; if (res !== 32'hF800_0000) begin errors++; $display("FAIL sra got %h expected f8000000", res); end
    issue1(4'd9, 32'd4, 32'h8000_0000);
    checks++; if (res !== 32'h0800_0000) begin errors++; $display("FAIL srl got %h expected 08000000", res); end
    issue1(4'd8, 32'd33, 32'h0000_0003);
    checks++; if (res !== 32'h0000_0006) begin errors++; $display("FAIL sll_wrap got %h expected 00000006", res); end
    issue1(4'd1, 32'd5, 32'd7);
    checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub got %h expected fffffffe", res); end
    issue1(4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF);
    checks++; if (res !== 32'hFF00_EDCB) begin errors++; $display("FAIL xor got %h expected ff00edcb", res); end
    issue1(4'd6, 32'hF0F0_0000, 32'h0000_000F);
    checks++; if (res !== 32'h0F0F_FFF0) begin errors++; $display("FAIL nor got %h expected 0f0ffff0", res); end
    issue1(4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0);
    checks++; if (res !== 32'h0F00_0F00) begin errors++; $display("FAIL and got %h expected 0f000f00", res); end
    issue1(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if (res !== 32'd0) begin errors++; $display("FAIL reserved got %h expected 0", res); end
    checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL single_hi_kept got %h expected 0", hi); end
  endtask

  task automatic test_mult;
    int lat, low;
    run_md32(4'd11, 32'hFFFF_FFFD, 32'd7, lat, low);
    checks++; if (lat !== 32)  begin errors++; $display("FAIL mult_latency got %0d expected 32", lat); end
    checks++; if (low !== 31)  begin errors++; $display("FAIL mult_ready_low got %0d expected 31", low); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h expected ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got %h expected ffffffeb", lo); end
    checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_res got %h expected ffffffeb", res); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b expected 0", done); end
    run_md32(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, low);
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h expected fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h expected 00000001", lo); end
  endtask

  task automatic test_div;
    int lat, low;
    run_md32(4'd13, 32'hFFFF_FFF9, 32'd2, lat, low);
    checks++; if (lat !== 32) begin errors++; $display("FAIL div_latency got %0d expected 32", lat); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h expected fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h expected ffffffff", hi); end
    run_md32(4'd14, 32'd5, 32'd0, lat, low);
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo got %h expected ffffffff", lo); end
    checks++; if (hi !== 32'd5) begin errors++; $display("FAIL divu0_hi got %h expected 5", hi); end
    run_md32(4'd13, 32'hFFFF_FFFB, 32'd0, lat, low);
    checks++; if (lo !== 32'd1) begin errors++; $display("FAIL div0neg_lo got %h expected 1", lo); end
    checks++; if (hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL div0neg_hi got %h expected fffffffb", hi); end
    run_md32(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, lat, low);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got %h expected 80000000", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL divovf_hi got %h expected 0", hi); end
    run_md32(4'd14, 32'd100, 32'd7, lat, low);
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %h expected 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %h expected 2", hi); end
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_res got %h expected 0000000e", res); end
  endtask

  task automatic test_flush;
    int dones;
    // flush at iteration 10 of a MULTU
    @(negedge clk);
    valid = 1'b1; op = 4'd12; a = 32'h0001_0000; b = 32'h0001_0000;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      valid = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b expected 1", ready); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL flush_done got %b expected 0", done); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL flush_late_done got %0d expected 0", dones); end
    checks++; if (hi !== 32'd2)  begin errors++; $display("FAIL flush_hi got %h expected 2", hi); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL flush_lo got %h expected 0000000e", lo); end
    issue1(4'd0, 32'd2, 32'd3);
    checks++; if (res !== 32'd5) begin errors++; $display("FAIL flush_add_res got %h expected 5", res); end
    // flush on the completion edge of a MULTU
    @(negedge clk);
    valid = 1'b1; op = 4'd12; a = 32'd3; b = 32'd5;
    @(posedge clk);
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      valid = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flushlast_done got %b expected 0", done); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL flushlast_lo got %h expected 0000000e", lo); end
    checks++; if (res !== 32'd5) begin errors++; $display("FAIL flushlast_res got %h expected 5", res); end
    // flush together with a request: not accepted
    valid = 1'b1; op = 4'd0; a = 32'd10; b = 32'd10; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flushreq_done got %b expected 0", done); end
    checks++; if (res !== 32'd5) begin errors++; $display("FAIL flushreq_res got %h expected 5", res); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    valid = 1'b1; op = 4'd13; a = 32'd100; b = 32'd3;
    @(posedge clk);
    repeat (5) @(negedge clk);
    valid = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b1)  begin errors++; $display("FAIL midrst_ready got %b expected 1", ready); end
    checks++; if (res !== 32'd0)   begin errors++; $display("FAIL midrst_res got %h expected 0", res); end
    checks++; if (hi !== 32'd0)    begin errors++; $display("FAIL midrst_hi got %h expected 0", hi); end
    checks++; if (lo !== 32'd0)    begin errors++; $display("FAIL midrst_lo got %h expected 0", lo); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL postrst_ready got %b expected 1", ready); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL postrst_done got %b expected 0", done); end
  endtask

  task automatic test_width8;
    int lat, low;
    @(negedge clk);
    valid8 = 1'b1; op8 = 4'd12; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk);
    lat = 0; low = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      valid8 = 1'b0;
      if (!ready8) low++;
      if (done8) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat !== 8) begin errors++; $display("FAIL w8_latency got %0d expected 8", lat); end
    checks++; if (low !== 7) begin errors++; $display("FAIL w8_ready_low got %0d expected 7", low); end
    checks++; if (hi8 !== 8'hFE) begin errors++; $display("FAIL w8_hi got %h expected fe", hi8); end
    checks++; if (lo8 !== 8'h01) begin errors++; $display("FAIL w8_lo got %h expected 01", lo8); end
    @(negedge clk);
    valid8 = 1'b1; op8 = 4'd13; a8 = 8'hF9; b8 = 8'h02;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      valid8 = 1'b0;
      if (done8) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat !== 8) begin errors++; $display("FAIL w8_div_latency got %0d expected 8", lat); end
    checks++; if (lo8 !== 8'hFD) begin errors++; $display("FAIL w8_div_lo got %h expected fd", lo8); end
    checks++; if (hi8 !== 8'hFF) begin errors++; $display("FAIL w8_div_hi got %h expected ff", hi8); end
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; op = 4'd0; a = '0; b = '0; flush = 1'b0;
    valid8 = 1'b0; op8 = 4'd0; a8 = '0; b8 = '0; flush8 = 1'b0;
    test_reset;
    test_back_to_back;
    test_logic_shift;
    test_mult;
    test_div;
    test_flush;
    test_reset_mid;
    test_width8;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
